// File: rtl/spi_host.sv
// Mode-0 SPI host: one command byte with dc low, then N data bytes with dc high.
// MISO bytes from the data phase come back on a valid-only stream.
module spi_host #(
    parameter int CLK_DIV   = 3,
    parameter int SETUP_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_vld_i,
    output logic       cmd_rdy_o,
    input  logic [7:0] cmd_byte_i,
    input  logic [7:0] data_len_i,
    input  logic       tx_vld_i,
    output logic       tx_rdy_o,
    input  logic [7:0] tx_data_i,
    output logic       rx_vld_o,
    output logic [7:0] rx_data_o,
    output logic       done_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_n_o,
    output logic       dc_o,
    input  logic       spi_miso_i
);

    localparam int CW = 16;
    localparam logic [CW-1:0] DIV_M1   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_M1 = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] GAP_M1   = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_GAP,
        S_DATA_WAIT,
        S_CS_HOLD
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic          r_cmd_phase;
    logic [7:0]    r_left;
    logic [7:0]    r_tx_sh;
    logic [7:0]    r_rx_sh;
    logic          r_sclk;
    logic          r_mosi;
    logic          r_cs_n;
    logic          r_dc;
    logic          r_rx_vld;
    logic [7:0]    r_rx_data;
    logic          r_done;
    logic          r_cmd_rdy;
    logic          r_tx_rdy;
    logic          w_last;

    // r_left still holds the full count while the command byte is shifting
    assign w_last = r_cmd_phase ? (r_left == 8'd0) : (r_left == 8'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_cmd_phase <= 1'b0;
            r_left      <= '0;
            r_tx_sh     <= '0;
            r_rx_sh     <= '0;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_dc        <= 1'b0;
            r_rx_vld    <= 1'b0;
            r_rx_data   <= '0;
            r_done      <= 1'b0;
            r_cmd_rdy   <= 1'b1;
            r_tx_rdy    <= 1'b0;
        end else begin
            r_rx_vld <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_vld_i) begin
                        r_state     <= S_CS_SETUP;
                        r_cmd_rdy   <= 1'b0;
                        r_cs_n      <= 1'b0;
                        r_dc        <= 1'b0;
                        r_cnt       <= SETUP_M1;
                        r_tx_sh     <= cmd_byte_i;
                        r_left      <= data_len_i;
                        r_cmd_phase <= 1'b1;
                    end
                end
                S_CS_SETUP: begin
                    if (r_cnt == '0) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= DIV_M1;
                        r_bit   <= '0;
                        r_mosi  <= r_tx_sh[7];
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (!r_sclk) begin
                        r_sclk  <= 1'b1;
                        r_cnt   <= DIV_M1;
                        r_rx_sh <= {r_rx_sh[6:0], spi_miso_i};
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit != 3'd7) begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                            r_mosi  <= r_tx_sh[6];
                            r_cnt   <= DIV_M1;
                        end else begin
                            r_cmd_phase <= 1'b0;
                            if (!r_cmd_phase) begin
                                r_rx_vld  <= 1'b1;
                                r_rx_data <= r_rx_sh;
                                r_left    <= r_left - 8'd1;
                            end
                            if (w_last) begin
                                r_state <= S_CS_HOLD;
                                r_cnt   <= SETUP_M1;
                            end else begin
                                r_state <= S_GAP;
                                r_cnt   <= GAP_M1;
                                r_dc    <= 1'b1;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state  <= S_DATA_WAIT;
                        r_tx_rdy <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DATA_WAIT: begin
                    if (tx_vld_i) begin
                        r_state  <= S_SHIFT;
                        r_tx_rdy <= 1'b0;
                        r_tx_sh  <= tx_data_i;
                        r_mosi   <= tx_data_i[7];
                        r_cnt    <= DIV_M1;
                        r_bit    <= '0;
                    end
                end
                S_CS_HOLD: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_IDLE;
                        r_cs_n    <= 1'b1;
                        r_dc      <= 1'b0;
                        r_mosi    <= 1'b0;
                        r_done    <= 1'b1;
                        r_cmd_rdy <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cs_n    <= 1'b1;
                    r_sclk    <= 1'b0;
                    r_cmd_rdy <= 1'b1;
                    r_tx_rdy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_rdy_o  = r_cmd_rdy;
    assign tx_rdy_o   = r_tx_rdy;
    assign rx_vld_o   = r_rx_vld;
    assign rx_data_o  = r_rx_data;
    assign done_o     = r_done;
    assign spi_sclk_o = r_sclk;
    assign spi_mosi_o = r_mosi;
    assign spi_cs_n_o = r_cs_n;
    assign dc_o       = r_dc;

endmodule

// File: tb/tb_spi_host.sv
// Randomized scoreboard bench for spi_host: a driver queues expectations,
// a negedge monitor decodes the SPI bus and output streams against them.
module tb_spi_host;

    localparam int CLK_DIV   = 3;
    localparam int SETUP_CYC = 4;
    localparam int GAP_CYC   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n_i;
    logic       cmd_vld_i;
    logic       cmd_rdy_o;
    logic [7:0] cmd_byte_i;
    logic [7:0] data_len_i;
    logic       tx_vld_i;
    logic       tx_rdy_o;
    logic [7:0] tx_data_i;
    logic       rx_vld_o;
    logic [7:0] rx_data_o;
    logic       done_o;
    logic       spi_sclk_o;
    logic       spi_mosi_o;
    logic       spi_cs_n_o;
    logic       dc_o;
    logic       spi_miso_i;

    bit         loop_mode = 1'b1;
    logic [7:0] sl_cur = 8'h00;
    int         bitn = 0;

    assign spi_miso_i = loop_mode ? spi_mosi_o : sl_cur[3'(7 - bitn)];

    spi_host #(
        .CLK_DIV  (CLK_DIV),
        .SETUP_CYC(SETUP_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n_i),
        .cmd_vld_i (cmd_vld_i),
        .cmd_rdy_o (cmd_rdy_o),
        .cmd_byte_i(cmd_byte_i),
        .data_len_i(data_len_i),
        .tx_vld_i  (tx_vld_i),
        .tx_rdy_o  (tx_rdy_o),
        .tx_data_i (tx_data_i),
        .rx_vld_o  (rx_vld_o),
        .rx_data_o (rx_data_o),
        .done_o    (done_o),
        .spi_sclk_o(spi_sclk_o),
        .spi_mosi_o(spi_mosi_o),
        .spi_cs_n_o(spi_cs_n_o),
        .dc_o      (dc_o),
        .spi_miso_i(spi_miso_i)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // expected {dc, byte} per SPI byte, rx bytes, tx_rdy run lengths,
    // done latency (cycles from accept), sclk rises per transaction
    logic [8:0] q_spi[$];
    logic [7:0] q_rx[$];
    int         q_rdy[$];
    int         q_lat[$];
    int         q_rises[$];
    logic [7:0] sl_q[$];

    int         cyc = 0;
    int         hs_cyc = 0;
    int         rises = 0;
    int         low_run = 0;
    int         rdy_run = 0;
    int         nbytes = 0;
    int         done_cnt = 0;
    bit         in_txn = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_rdy = 1'b0;
    logic       prev_mosi = 1'b0;
    logic       mdc = 1'b0;
    logic [7:0] mbyte = 8'h00;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n_i) begin
            q_spi.delete();
            q_rx.delete();
            q_rdy.delete();
            q_lat.delete();
            q_rises.delete();
            sl_q.delete();
            in_txn    = 1'b0;
            rises     = 0;
            bitn      = 0;
            nbytes    = 0;
            rdy_run   = 0;
            low_run   = 0;
            prev_sclk = 1'b0;
            prev_rdy  = 1'b0;
            prev_mosi = 1'b0;
        end else begin
            if (in_txn && cyc > hs_cyc && !done_o)
                chk("cs_held", 32'(spi_cs_n_o), 0);
            if (cmd_vld_i && cmd_rdy_o) begin
                hs_cyc  = cyc;
                in_txn  = 1'b1;
                rises   = 0;
                bitn    = 0;
                nbytes  = 0;
                low_run = 0;
                sl_cur  = (sl_q.size() > 0) ? sl_q.pop_front() : 8'h00;
            end
            if (spi_sclk_o && !prev_sclk) begin
                rises++;
                if (bitn == 0) begin
                    mdc = dc_o;
                    if (nbytes > 0)
                        chk("gap_low", 32'(low_run >= GAP_CYC + 1), 1);
                end else begin
                    chk("dc_stable", 32'(dc_o), 32'(mdc));
                end
                mbyte = {mbyte[6:0], spi_mosi_o};
                bitn++;
                if (bitn == 8) begin
                    bitn = 0;
                    nbytes++;
                    chk("spi_expected", 32'(q_spi.size() > 0), 1);
                    if (q_spi.size() > 0)
                        chk("spi_byte", 32'({mdc, mbyte}), 32'(q_spi.pop_front()));
                    sl_cur = (sl_q.size() > 0) ? sl_q.pop_front() : 8'h00;
                end
            end
            if (spi_sclk_o && prev_sclk)
                chk("mosi_hold", 32'(spi_mosi_o), 32'(prev_mosi));
            low_run = spi_sclk_o ? 0 : low_run + 1;
            if (tx_rdy_o) begin
                rdy_run++;
                chk("wait_quiet", 32'({spi_sclk_o, spi_cs_n_o}), 0);
            end else if (prev_rdy) begin
                chk("rdy_expected", 32'(q_rdy.size() > 0), 1);
                if (q_rdy.size() > 0)
                    chk("rdy_run", rdy_run, q_rdy.pop_front());
                rdy_run = 0;
            end
            if (rx_vld_o) begin
                chk("rx_expected", 32'(q_rx.size() > 0), 1);
                if (q_rx.size() > 0)
                    chk("rx_data", 32'(rx_data_o), 32'(q_rx.pop_front()));
            end
            if (done_o) begin
                chk("done_expected", 32'(q_lat.size() > 0), 1);
                if (q_lat.size() > 0)
                    chk("done_latency", cyc - hs_cyc, q_lat.pop_front());
                if (q_rises.size() > 0)
                    chk("sclk_rises", rises, q_rises.pop_front());
                chk("done_idle",
                    32'({cmd_rdy_o, spi_cs_n_o, dc_o, spi_mosi_o, tx_rdy_o}),
                    32'(5'b11000));
                in_txn = 1'b0;
                done_cnt++;
            end
            prev_sclk = spi_sclk_o;
            prev_rdy  = tx_rdy_o;
            prev_mosi = spi_mosi_o;
        end
    end

    task automatic wait_cmd_hs();
        int ok = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cmd_rdy_o && cmd_vld_i) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_accept", ok, 1);
        @(posedge clk);
        #1;
        cmd_vld_i = 1'b0;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] tx[$],
                           input bit loop, input int stall_idx);
        int n = tx.size();
        int ok;
        int d0;
        logic [7:0] sb;
        bit stalled = (stall_idx >= 0 && stall_idx < n);
        loop_mode = loop;
        q_spi.push_back({1'b0, cmd});
        sb = 8'($urandom);
        sl_q.push_back(sb);
        for (int i = 0; i < n; i++) begin
            q_spi.push_back({1'b1, tx[i]});
            sb = 8'($urandom);
            sl_q.push_back(sb);
            q_rx.push_back(loop ? tx[i] : sb);
            q_rdy.push_back((i == stall_idx) ? 21 : 1);
        end
        q_lat.push_back(SETUP_CYC * 2 + 1 + 16 * CLK_DIV
                        + n * (GAP_CYC + 1 + 16 * CLK_DIV)
                        + (stalled ? 20 : 0));
        q_rises.push_back(8 * (n + 1));
        cmd_byte_i = cmd;
        data_len_i = 8'(n);
        cmd_vld_i  = 1'b1;
        wait_cmd_hs();
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                tx_vld_i = 1'b0;
                ok = 0;
                for (int k = 0; k < 2000; k++) begin
                    if (tx_rdy_o) begin
                        ok = 1;
                        break;
                    end
                    @(posedge clk);
                    #1;
                end
                chk("stall_rdy_seen", ok, 1);
                repeat (5) @(posedge clk);
                #1;
                cmd_byte_i = 8'hFF;
                cmd_vld_i  = 1'b1;
                chk("stall_cmd_ignored", 32'(cmd_rdy_o), 0);
                @(posedge clk);
                #1;
                cmd_vld_i = 1'b0;
                repeat (14) @(posedge clk);
                #1;
            end
            tx_data_i = tx[i];
            tx_vld_i  = 1'b1;
            ok = 0;
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (tx_rdy_o) begin
                    ok = 1;
                    break;
                end
            end
            chk("tx_accept", ok, 1);
            @(posedge clk);
            #1;
            tx_vld_i = 1'b0;
        end
        d0 = done_cnt;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        chk("done_seen", ok, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0] tx[$];
    int         stall;
    int         nlen;
    int         ok;

    initial begin
        rst_n_i    = 1'b0;
        cmd_vld_i  = 1'b0;
        tx_vld_i   = 1'b0;
        cmd_byte_i = 8'h00;
        data_len_i = 8'h00;
        tx_data_i  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(spi_cs_n_o), 1);
        chk("rst_sclk", 32'(spi_sclk_o), 0);
        chk("rst_mosi", 32'(spi_mosi_o), 0);
        chk("rst_dc", 32'(dc_o), 0);
        chk("rst_cmd_rdy", 32'(cmd_rdy_o), 1);
        chk("rst_tx_rdy", 32'(tx_rdy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_rx_vld", 32'(rx_vld_o), 0);
        chk("rst_rx_data", 32'(rx_data_o), 0);
        rst_n_i = 1'b1;
        @(posedge clk);
        #1;

        tx.delete();
        run_txn(8'h2A, tx, 1'b1, -1);

        tx = '{8'h0A, 8'h00, 8'h00, 8'h00};
        run_txn(8'h2A, tx, 1'b0, -1);

        tx.delete();
        for (int i = 1; i <= 8; i++) tx.push_back(8'(i));
        run_txn(8'h3A, tx, 1'b1, -1);

        tx.delete();
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
        run_txn(8'($urandom), tx, 1'b0, 1);

        // abort partway through the first data byte
        loop_mode  = 1'b1;
        q_spi.push_back({1'b0, 8'h5C});
        q_rdy.push_back(1);
        tx_data_i  = 8'hC3;
        tx_vld_i   = 1'b1;
        cmd_byte_i = 8'h5C;
        data_len_i = 8'd2;
        cmd_vld_i  = 1'b1;
        wait_cmd_hs();
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (rises >= 11) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("abort_reach", ok, 1);
        rst_n_i = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_spi", 32'({spi_cs_n_o, spi_sclk_o, dc_o, spi_mosi_o}),
            32'(4'b1000));
        chk("abort_ctrl", 32'({cmd_rdy_o, tx_rdy_o, done_o, rx_vld_o}),
            32'(4'b1000));
        rst_n_i  = 1'b1;
        tx_vld_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tx = '{8'h96, 8'h5A};
        run_txn(8'hA5, tx, 1'b0, -1);

        for (int t = 0; t < 12; t++) begin
            nlen = int'($urandom_range(0, 5));
            tx.delete();
            for (int i = 0; i < nlen; i++) tx.push_back(8'($urandom));
            stall = -1;
            if (nlen > 0 && $urandom_range(0, 2) == 0)
                stall = int'($urandom_range(0, nlen - 1));
            run_txn(8'($urandom), tx, 1'($urandom), stall);
        end

        chk("left_spi", q_spi.size(), 0);
        chk("left_rx", q_rx.size(), 0);
        chk("left_rdy", q_rdy.size(), 0);
        chk("left_done", q_lat.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
